// File: rtl/cpu_io_pkg.sv
// Shared widths and defaults for the CPU I/O host block.
package cpu_io_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH_LOG2_DEF = 3;
  localparam logic [DATA_W-1:0] EMPTY_VALUE_DEF = 8'h00;
  localparam int LEVEL_W_DEF = DEPTH_LOG2_DEF + 1;

  // Width of an occupancy counter that must be able to hold DEPTH itself.
  function automatic int level_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/cpu_io_host_if.sv
// Bundles the CPU-side I/O strobes and the two host streams of cpu_io_host.
// The slave modport is the view taken by cpu_io_host; master is the peer side.
interface cpu_io_host_if
  import cpu_io_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) ();

  // CPU side
  logic              IEnable;
  logic              OEnable;
  logic [DATA_W-1:0] O;
  logic [DATA_W-1:0] I;

  // Host input stream (host -> CPU)
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  // Host output stream (CPU -> host)
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Status and control
  logic [DEPTH_LOG2:0] in_level;
  logic [DEPTH_LOG2:0] out_level;
  logic                underflow;
  logic                overflow;
  logic                clr_flags;

  modport slave (
    input  IEnable, OEnable, O, in_data, in_valid, out_ready, clr_flags,
    output I, in_ready, out_data, out_valid, in_level, out_level, underflow, overflow
  );

  modport master (
    output IEnable, OEnable, O, in_data, in_valid, out_ready, clr_flags,
    input  I, in_ready, out_data, out_valid, in_level, out_level, underflow, overflow
  );

endinterface

// File: rtl/cpu_io_host_byte_fifo.sv
// Circular byte FIFO with an explicit occupancy counter.
// Exposes the head entry and the one behind it so the owner can present a
// lookahead byte. The caller is responsible for only pushing when there is
// room (or when a pop frees a slot in the same cycle) and only popping when
// non-empty.
module byte_fifo
  import cpu_io_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int WIDTH      = DATA_W
) (
  input  logic                  clk_out,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      head,
  output logic                  head_vld,
  output logic [WIDTH-1:0]      nxt,
  output logic                  nxt_vld,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_nxt;
  logic [DEPTH_LOG2:0]   level_q;

  assign rd_nxt = rd_ptr + PTR_ONE;

  // Pointers wrap naturally at DEPTH; level moves by at most one per cycle.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is not reset; validity comes only from the level counter.
  always_ff @(posedge clk_out) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign head     = mem[rd_ptr];
  assign nxt      = mem[rd_nxt];
  assign head_vld = (level_q != '0);
  assign nxt_vld  = (level_q > LVL_ONE);
  assign full     = (level_q == LVL_FULL);
  assign level    = level_q;

endmodule

// File: rtl/cpu_io_host.sv
// Host-side peer of the CPU I/O port.
// The input FIFO feeds the CPU's I byte, one entry consumed per IEnable.
// The output FIFO captures O on each OEnable and is drained by the host.
// The CPU never stalls, so lost traffic is only reported through the sticky
// underflow / overflow flags.
module cpu_io_host
  import cpu_io_pkg::*;
#(
  parameter int                DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter logic [DATA_W-1:0] EMPTY_VALUE = EMPTY_VALUE_DEF
) (
  input  logic         clk_out,
  input  logic         rst,
  cpu_io_host_if.slave bus
);

  // Input path (host -> CPU)
  logic              in_push;
  logic              in_pop;
  logic [DATA_W-1:0] in_head;
  logic              in_head_vld;
  logic [DATA_W-1:0] in_nxt;
  logic              in_nxt_vld;
  logic [DEPTH_LOG2:0] in_level;
  logic              in_full;

  // Output path (CPU -> host)
  logic              out_push;
  logic              out_pop;
  logic [DATA_W-1:0] out_head;
  logic              out_head_vld;
  logic [DATA_W-1:0] out_nxt_unused;
  logic              out_nxt_vld_unused;
  logic [DEPTH_LOG2:0] out_level;
  logic              out_full;

  // Flags
  logic underflow_set;
  logic overflow_set;
  logic underflow_q;
  logic overflow_q;

  // A full input FIFO refuses the host even when the CPU pops that cycle.
  assign in_push = bus.in_valid && !in_full;
  assign in_pop  = bus.IEnable && in_head_vld;
  assign underflow_set = bus.IEnable && !in_head_vld;

  // A full output FIFO still accepts the CPU byte if the host frees a slot now.
  assign out_pop      = out_head_vld && bus.out_ready;
  assign out_push     = bus.OEnable && (!out_full || out_pop);
  assign overflow_set = bus.OEnable && out_full && !out_pop;

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (DATA_W)
  ) u_in_fifo (
    .clk_out  (clk_out),
    .rst      (rst),
    .push     (in_push),
    .pop      (in_pop),
    .wr_data  (bus.in_data),
    .head     (in_head),
    .head_vld (in_head_vld),
    .nxt      (in_nxt),
    .nxt_vld  (in_nxt_vld),
    .level    (in_level),
    .full     (in_full)
  );

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (DATA_W)
  ) u_out_fifo (
    .clk_out  (clk_out),
    .rst      (rst),
    .push     (out_push),
    .pop      (out_pop),
    .wr_data  (bus.O),
    .head     (out_head),
    .head_vld (out_head_vld),
    .nxt      (out_nxt_unused),
    .nxt_vld  (out_nxt_vld_unused),
    .level    (out_level),
    .full     (out_full)
  );

  // I lookahead: while IEnable is high the head is already spoken for, so the
  // CPU must see the entry behind it. Only registered FIFO state feeds this.
  always_comb begin
    bus.I = EMPTY_VALUE;
    if (bus.IEnable) begin
      if (in_nxt_vld) bus.I = in_nxt;
    end else begin
      if (in_head_vld) bus.I = in_head;
    end
  end

  // Sticky loss flags; a new loss event in the same cycle beats the clear.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (underflow_set)      underflow_q <= 1'b1;
      else if (bus.clr_flags) underflow_q <= 1'b0;
      if (overflow_set)       overflow_q  <= 1'b1;
      else if (bus.clr_flags) overflow_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = !in_full;
  assign bus.out_valid = out_head_vld;
  assign bus.out_data  = out_head_vld ? out_head : EMPTY_VALUE;
  assign bus.in_level  = in_level;
  assign bus.out_level = out_level;
  assign bus.underflow = underflow_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_cpu_io_host.sv
// Directed bench for cpu_io_host with a queue-based reference model.
// Host bytes are queued when accepted and checked against the byte the CPU
// saw when it consumes; CPU bytes are queued when captured and checked as the
// host drains them.
module tb_cpu_io_host;

  logic clk_out;
  logic rst;

  cpu_io_host_if bus ();

  cpu_io_host dut (
    .clk_out (clk_out),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_in  [$];
  logic [7:0] m_out [$];
  logic       m_uf;
  logic       m_ov;
  logic [7:0] last_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.IEnable   = 1'b0;
    bus.OEnable   = 1'b0;
    bus.O         = 8'h00;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_flags = 1'b0;
  endtask

  task automatic model_reset();
    m_in.delete();
    m_out.delete();
    m_uf   = 1'b0;
    m_ov   = 1'b0;
    last_i = 8'h00;
  endtask

  // One clock: compare outputs against the model at the negedge, advance the
  // model with the current inputs, then return just after the posedge.
  task automatic tick();
    logic [7:0] exp_i;
    logic       in_pop, in_push, out_pop, out_push, uf_set, ov_set;
    @(negedge clk_out);
    if (bus.IEnable) exp_i = (m_in.size() >= 2) ? m_in[1] : 8'h00;
    else             exp_i = (m_in.size() >= 1) ? m_in[0] : 8'h00;
    check("I", bus.I, exp_i);
    check("in_level", bus.in_level, m_in.size());
    check("out_level", bus.out_level, m_out.size());
    check("in_ready", bus.in_ready, m_in.size() != 8);
    check("out_valid", bus.out_valid, m_out.size() != 0);
    check("underflow", bus.underflow, m_uf);
    check("overflow", bus.overflow, m_ov);
    if (m_out.size() == 0) check("out_data_empty", bus.out_data, 8'h00);

    in_pop   = bus.IEnable && (m_in.size() != 0);
    in_push  = bus.in_valid && (m_in.size() != 8);
    uf_set   = bus.IEnable && (m_in.size() == 0);
    out_pop  = (m_out.size() != 0) && bus.out_ready;
    out_push = bus.OEnable && ((m_out.size() != 8) || out_pop);
    ov_set   = bus.OEnable && (m_out.size() == 8) && !out_pop;

    if (in_pop) check("cpu_read", last_i, m_in.pop_front());
    if (out_pop) check("out_data", bus.out_data, m_out.pop_front());
    if (in_push)  m_in.push_back(bus.in_data);
    if (out_push) m_out.push_back(bus.O);
    if (uf_set) m_uf = 1'b1; else if (bus.clr_flags) m_uf = 1'b0;
    if (ov_set) m_ov = 1'b1; else if (bus.clr_flags) m_ov = 1'b0;
    last_i = bus.I;
    @(posedge clk_out);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_out);
    #1;
    check("rst_in_level", bus.in_level, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_I", bus.I, 8'h00);
    check("rst_out_data", bus.out_data, 8'h00);
    rst = 1'b0;
    tick();

    // 1: reset mid-traffic with 3 bytes queued each way and a flag raised
    bus.IEnable = 1'b1;
    tick();
    bus.IEnable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'h40 + 8'(k);
      bus.OEnable  = 1'b1; bus.O       = 8'h50 + 8'(k);
      tick();
    end
    idle();
    tick();
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_in_level", bus.in_level, 0);
    check("rst_mid_out_level", bus.out_level, 0);
    check("rst_mid_I", bus.I, 8'h00);
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_underflow", bus.underflow, 0);
    check("rst_mid_overflow", bus.overflow, 0);
    model_reset();
    @(posedge clk_out);
    #1;
    rst = 1'b0;
    tick();

    // 2: three bytes in, then consumed back-to-back
    bus.in_valid = 1'b1;
    bus.in_data = 8'h11; tick();
    bus.in_data = 8'h22; tick();
    bus.in_data = 8'h33; tick();
    bus.in_valid = 1'b0;
    tick();
    bus.IEnable = 1'b1;
    repeat (3) tick();
    bus.IEnable = 1'b0;
    tick();

    // 3: underflow on empty, clear loses to a simultaneous new underflow
    bus.IEnable = 1'b1;
    tick();
    bus.clr_flags = 1'b1;
    tick();
    bus.IEnable = 1'b0;
    tick();
    bus.clr_flags = 1'b0;
    tick();

    // 4: nine CPU bytes into an eight-deep FIFO, then drain
    bus.OEnable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.O = 8'hA0 + 8'(k);
      tick();
    end
    bus.OEnable = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    repeat (8) tick();
    bus.out_ready = 1'b0;
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    tick();

    // 5: full output FIFO, CPU write and host pop on the same edge
    bus.OEnable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.O = 8'hC0 + 8'(k);
      tick();
    end
    bus.O = 8'h5C;
    bus.out_ready = 1'b1;
    tick();
    bus.OEnable = 1'b0;
    repeat (9) tick();
    bus.out_ready = 1'b0;
    tick();

    // 6: overlapping push/pop stream through the pointer wrap
    for (int k = 0; k < 22; k++) begin
      bus.in_valid = (k < 20);
      bus.in_data  = 8'(k);
      bus.IEnable  = (k >= 2);
      tick();
    end
    idle();
    tick();
    check("wrap_final_level", bus.in_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
